// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo position loop: FSM state encoding
// and a range clamp used for both the duty limit and integrator saturation.
package servo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        ERR,
        MAC_P,
        MAC_I,
        MAC_D,
        SAT,
        UPD
    } state_t;

    function automatic longint clamp_range(input longint v, input longint lo, input longint hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Free-running PWM with a shadow duty register that is transferred to the
// comparator only at the end of a period, so a period is never cut short.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PWM_W = 10
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty_i,
    input  logic             load_i,
    output logic             PWM_o
);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [PWM_W-1:0] counter;
    logic [PWM_W-1:0] shadow;
    logic [PWM_W-1:0] active;

    // A load landing on the wrap cycle bypasses the shadow so it takes effect immediately.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            counter <= '0;
            shadow  <= '0;
            active  <= '0;
        end else begin
            counter <= counter + 1'b1;
            if (load_i) begin
                shadow <= duty_i;
            end
            if (counter == CNT_MAX) begin
                active <= load_i ? duty_i : shadow;
            end
        end
    end

    assign PWM_o = (counter < active);

endmodule

// File: rtl/servo_ipd_pwm.sv
// I-PD position servo: one sample per strobe, shared multiplier, clamped duty
// fed to a glitch-free PWM. Define SERVO_ANTIWINDUP_EN for integrator anti-windup.
module servo_ipd_pwm
    import servo_pkg::*;
#(
    parameter int W     = 12,
    parameter int PWM_W = 10,
    parameter int ACC_W = 24,
    parameter int FRAC  = 4,
    parameter int KP    = 1,
    parameter int KI    = 1,
    parameter int KD    = 0
) (
    input  logic         clk_i,
    input  logic         reset,
    input  logic [W-1:0] ADC_i,
    input  logic         dataf_i,
    input  logic [W-1:0] ref_i,
    output logic         PWM_o,
    output logic [W-1:0] LEDS_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         overrun_o
);

    localparam longint DUTY_MAX = (longint'(1) << PWM_W) - 1;
`ifdef SERVO_ANTIWINDUP_EN
    localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));
`endif

    state_t state;
    state_t state_next;

    logic [W-1:0]             y;
    logic [W-1:0]             r;
    logic [W-1:0]             y_prev;
    logic signed [W:0]        e;
    logic signed [W:0]        dy;
    logic signed [ACC_W-1:0]  integ;
    logic signed [ACC_W-1:0]  integ_next;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  mul_a;
    logic signed [ACC_W-1:0]  mul_b;
    logic signed [ACC_W-1:0]  prod;
    logic [PWM_W-1:0]         u;
    logic                     overrun;
    longint                   sat_val;
`ifdef SERVO_ANTIWINDUP_EN
    logic                     clamp_hi;
    logic                     clamp_lo;
`endif

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = (state != IDLE);
        done_o     = (state == UPD);
        case (state)
            IDLE:    if (dataf_i) state_next = CAPT;
            CAPT:    state_next = ERR;
            ERR:     state_next = MAC_P;
            MAC_P:   state_next = MAC_I;
            MAC_I:   state_next = MAC_D;
            MAC_D:   state_next = SAT;
            SAT:     state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single multiplier: gain and operand are steered by the MAC state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MAC_P: begin
                mul_a = ACC_W'(KP);
                mul_b = {{(ACC_W - W){1'b0}}, y};
            end
            MAC_I: begin
                mul_a = ACC_W'(KI);
                mul_b = {{(ACC_W - W - 1){e[W]}}, e};
            end
            MAC_D: begin
                mul_a = ACC_W'(KD);
                mul_b = {{(ACC_W - W - 1){dy[W]}}, dy};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    assign prod    = mul_a * mul_b;
    assign sat_val = longint'(sum) >>> FRAC;

    always_comb begin
        integ_next = integ + prod;
`ifdef SERVO_ANTIWINDUP_EN
        integ_next = ACC_W'(clamp_range(longint'(integ) + longint'(prod), ACC_MIN, ACC_MAX));
        // Hold the integrator while the output sits in a clamp it would only deepen.
        if ((clamp_hi && !prod[ACC_W-1] && (prod != '0)) || (clamp_lo && prod[ACC_W-1])) begin
            integ_next = integ;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            y       <= '0;
            r       <= '0;
            y_prev  <= '0;
            e       <= '0;
            dy      <= '0;
            integ   <= '0;
            sum     <= '0;
            u       <= '0;
            overrun <= 1'b0;
`ifdef SERVO_ANTIWINDUP_EN
            clamp_hi <= 1'b0;
            clamp_lo <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dataf_i) begin
                        y <= ADC_i;
                        r <= ref_i;
                    end
                end
                ERR: begin
                    e  <= $signed({1'b0, r}) - $signed({1'b0, y});
                    dy <= $signed({1'b0, y}) - $signed({1'b0, y_prev});
                end
                MAC_P: sum <= -prod;
                MAC_I: begin
                    integ <= integ_next;
                    sum   <= sum + integ_next;
                end
                MAC_D: sum <= sum - prod;
                SAT: begin
                    u <= PWM_W'(clamp_range(sat_val, 0, DUTY_MAX));
`ifdef SERVO_ANTIWINDUP_EN
                    clamp_hi <= (sat_val > DUTY_MAX);
                    clamp_lo <= (sat_val < 0);
`endif
                end
                UPD:     y_prev <= y;
                default: ;
            endcase
            if (dataf_i && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign LEDS_o    = y;
    assign overrun_o = overrun;

    servo_pwm_gen #(
        .PWM_W(PWM_W)
    ) u_pwm (
        .clk_i (clk_i),
        .reset (reset),
        .duty_i(u),
        .load_i(done_o),
        .PWM_o (PWM_o)
    );

endmodule
